// File: rtl/pattern_code_counter.sv
// pattern_code_counter: serial PAT_W-bit code detector with match counter.
// Samples x on every enabled rising cp. It pulses q for one cycle on each
// match of PATTERN, counts matches in cnt and raises a sticky ovf flag.
// Optional build macro PATTERN_CODE_COUNTER_SAT_EN makes cnt saturate at
// its maximum. When the macro is undefined, cnt wraps to zero instead.
module pattern_code_counter #(
  parameter int unsigned          PAT_W   = 4,
  parameter logic [PAT_W-1:0]     PATTERN = 4'b1011,
  parameter int unsigned          CNT_W   = 4,
  parameter bit                   OVERLAP = 1'b1
) (
  input  logic             cp,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             x,
  output logic             q,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [PAT_W-1:0]  hist;
  logic [FILL_W-1:0] fill;

  logic [PAT_W-1:0]  hist_n_c;
  logic [FILL_W-1:0] fill_n_c;
  logic              match_c;
  logic [CNT_W-1:0]  cnt_n_c;
  logic              ovf_set_c;

  // Next shift history, fill level and match decision for an enabled sample
  always_comb begin
    hist_n_c = (hist << 1) | PAT_W'(x);
    fill_n_c = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
    match_c  = (fill_n_c == FILL_FULL) && (hist_n_c == PATTERN);
  end

  // Counter value and overflow indication to apply on a match
  always_comb begin
    cnt_n_c   = cnt + CNT_W'(1);
    ovf_set_c = (cnt == CNT_MAX);
`ifdef PATTERN_CODE_COUNTER_SAT_EN
    if (cnt == CNT_MAX) begin
      cnt_n_c = CNT_MAX;
    end
`endif
  end

  // State update: reset, then clear, then enable gating, then shift step
  always_ff @(posedge cp or posedge reset) begin
    if (reset) begin
      hist <= '0;
      fill <= '0;
      q    <= 1'b0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
      q    <= 1'b0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else if (!en) begin
      q <= 1'b0;
    end else begin
      q <= match_c;
      if (match_c) begin
        cnt <= cnt_n_c;
        if (ovf_set_c) begin
          ovf <= 1'b1;
        end
      end
      if (match_c && (OVERLAP == 1'b0)) begin
        hist <= '0;
        fill <= '0;
      end else begin
        hist <= hist_n_c;
        fill <= fill_n_c;
      end
    end
  end

endmodule

// File: tb/tb_pattern_code_counter.sv
// tb_pattern_code_counter: directed bench for pattern_code_counter.
// It drives three configurations with one shared stimulus. Instance 0 uses
// the defaults. Instance 1 has OVERLAP=0. Instance 2 uses a 6-bit pattern
// with an 8-bit counter. A stream-level reference model checks every cycle,
// and literal expectations pin the key scenarios.
module tb_pattern_code_counter;

  logic cp = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic x = 1'b0;

  logic       q0, q1, q2;
  logic [3:0] cnt0, cnt1;
  logic [7:0] cnt2;
  logic       ovf0, ovf1, ovf2;

  int nvec = 0;
  int nerr = 0;

  always #5 cp = ~cp;

  pattern_code_counter u_dflt (
    .cp(cp), .reset(reset), .en(en), .clr(clr), .x(x),
    .q(q0), .cnt(cnt0), .ovf(ovf0)
  );

  pattern_code_counter #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(4), .OVERLAP(1'b0)) u_novl (
    .cp(cp), .reset(reset), .en(en), .clr(clr), .x(x),
    .q(q1), .cnt(cnt1), .ovf(ovf1)
  );

  pattern_code_counter #(.PAT_W(6), .PATTERN(6'b110010), .CNT_W(8), .OVERLAP(1'b1)) u_w6 (
    .cp(cp), .reset(reset), .en(en), .clr(clr), .x(x),
    .q(q2), .cnt(cnt2), .ovf(ovf2)
  );

  // Reference model: remembers the sampled stream since the last clear.
  // It counts matches as an unbounded integer.
  int unsigned m_pw[3]  = '{4, 4, 6};
  int unsigned m_cw[3]  = '{4, 4, 8};
  bit          m_ovl[3] = '{1'b1, 1'b0, 1'b1};
  logic [63:0] m_pat[3] = '{64'h0B, 64'h0B, 64'h32};

  logic [63:0] seen[3]   = '{64'd0, 64'd0, 64'd0};
  int          nseen[3]  = '{0, 0, 0};
  int          nmatch[3] = '{0, 0, 0};
  bit          qexp[3]   = '{1'b0, 1'b0, 1'b0};

  // Reference model update on every edge, including async reset
  always @(posedge cp or posedge reset) begin
    for (int k = 0; k < 3; k++) begin
      if (reset || clr) begin
        seen[k]   = '0;
        nseen[k]  = 0;
        nmatch[k] = 0;
        qexp[k]   = 1'b0;
      end else if (!en) begin
        qexp[k] = 1'b0;
      end else begin
        logic [63:0] mask;
        bit hit;
        seen[k]  = {seen[k][62:0], x};
        nseen[k] = nseen[k] + 1;
        mask     = (64'd1 << m_pw[k]) - 64'd1;
        hit      = (nseen[k] >= int'(m_pw[k])) && ((seen[k] & mask) == m_pat[k]);
        qexp[k]  = hit;
        if (hit) begin
          nmatch[k] = nmatch[k] + 1;
          if (!m_ovl[k]) nseen[k] = 0;
        end
      end
    end
  end

  function automatic int exp_cnt(int k);
    int mx;
    mx = (1 << m_cw[k]) - 1;
`ifdef PATTERN_CODE_COUNTER_SAT_EN
    return (nmatch[k] > mx) ? mx : nmatch[k];
`else
    return nmatch[k] % (mx + 1);
`endif
  endfunction

  function automatic int exp_ovf(int k);
    return (nmatch[k] > ((1 << m_cw[k]) - 1)) ? 1 : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    nvec = nvec + 1;
    if (act !== exp) begin
      nerr = nerr + 1;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge, all instances against the model
  always @(negedge cp) begin
    check("q0",   int'(q0),   int'(qexp[0]));
    check("cnt0", int'(cnt0), exp_cnt(0));
    check("ovf0", int'(ovf0), exp_ovf(0));
    check("q1",   int'(q1),   int'(qexp[1]));
    check("cnt1", int'(cnt1), exp_cnt(1));
    check("ovf1", int'(ovf1), exp_ovf(1));
    check("q2",   int'(q2),   int'(qexp[2]));
    check("cnt2", int'(cnt2), exp_cnt(2));
    check("ovf2", int'(ovf2), exp_ovf(2));
  end

  // One clock step: apply inputs, pass the next rising edge, settle 1 unit
  task automatic step(input logic e, input logic c, input logic b);
    en  = e;
    clr = c;
    x   = b;
    @(posedge cp);
    #1;
  endtask

  task automatic pat1011();
    step(1, 0, 1); step(1, 0, 0); step(1, 0, 1); step(1, 0, 1);
  endtask

  initial begin
    repeat (2) @(posedge cp);
    #1 reset = 1'b0;

    // Basic match: q on the 4th edge only, cnt 1
    step(1, 0, 1); step(1, 0, 0); step(1, 0, 1);
    check("basic_q_before", int'(q0), 0);
    step(1, 0, 1);
    check("basic_q", int'(q0), 1);
    check("basic_cnt", int'(cnt0), 1);
    step(1, 0, 0);
    check("basic_q_drop", int'(q0), 0);
    check("basic_cnt_hold", int'(cnt0), 1);

    // Reset mid-pattern, asserted between edges
    step(1, 0, 1); step(1, 0, 0); step(1, 0, 1);
    #3 reset = 1'b1;
    #1;
    check("rst_q", int'(q0), 0);
    check("rst_cnt", int'(cnt0), 0);
    check("rst_ovf", int'(ovf0), 0);
    #2 reset = 1'b0;
    step(1, 0, 1);
    check("rst_nomatch", int'(q0), 0);

    // Overlap versus non-overlap on 1011011
    step(1, 1, 0);
    pat1011();
    check("ovl_first_q0", int'(q0), 1);
    check("ovl_first_q1", int'(q1), 1);
    step(1, 0, 0); step(1, 0, 1); step(1, 0, 1);
    check("ovl_second_q0", int'(q0), 1);
    check("novl_second_q1", int'(q1), 0);
    check("ovl_cnt0", int'(cnt0), 2);
    check("novl_cnt1", int'(cnt1), 1);

    // Enable gaps are invisible
    step(1, 1, 0);
    step(1, 0, 1); step(1, 0, 0);
    step(0, 0, 1); step(0, 0, 0); step(0, 0, 1);
    step(1, 0, 1);
    check("gap_q_early", int'(q0), 0);
    step(1, 0, 1);
    check("gap_q", int'(q0), 1);
    check("gap_cnt", int'(cnt0), 1);

    // Clear wins over a completing bit
    step(1, 0, 1); step(1, 0, 0); step(1, 0, 1);
    step(1, 1, 1);
    check("clr_q", int'(q0), 0);
    check("clr_cnt", int'(cnt0), 0);

    // Overflow: 16 back-to-back matches, then a 17th
    step(1, 1, 0);
    repeat (16) pat1011();
`ifdef PATTERN_CODE_COUNTER_SAT_EN
    check("ovf16_cnt", int'(cnt0), 15);
`else
    check("ovf16_cnt", int'(cnt0), 0);
`endif
    check("ovf16_flag", int'(ovf0), 1);
    pat1011();
    check("ovf17_q", int'(q0), 1);
`ifdef PATTERN_CODE_COUNTER_SAT_EN
    check("ovf17_cnt", int'(cnt0), 15);
`else
    check("ovf17_cnt", int'(cnt0), 1);
`endif
    check("ovf17_flag", int'(ovf0), 1);

    // Wide pattern 110010 on stream 110010010
    step(1, 1, 0);
    step(1, 0, 1); step(1, 0, 1); step(1, 0, 0); step(1, 0, 0); step(1, 0, 1);
    check("w6_q_early", int'(q2), 0);
    step(1, 0, 0);
    check("w6_q", int'(q2), 1);
    check("w6_cnt", int'(cnt2), 1);
    step(1, 0, 0); step(1, 0, 1); step(1, 0, 0);
    check("w6_q_end", int'(q2), 0);
    check("w6_cnt_end", int'(cnt2), 1);

    step(0, 0, 0);
    @(negedge cp);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
